// File: rtl/demux16_router_pkg.sv
// Package for the demux16 router: default widths and the destination encoding.
package demux16_router_pkg;

`include "demux16_router_defs.svh"

    localparam int DEF_WIDTH = `WIDTH_DEFAULT;
    localparam int DEF_CNT_W = `CNT_W_DEFAULT;

    typedef enum logic {
        DEST_A = `SEL_A,
        DEST_B = `SEL_B
    } dest_e;

endpackage

// File: rtl/demux16_router_defs.svh
// Shared constants for the demux16 router slice: default widths and select encodings.
`ifndef DEMUX16_ROUTER_DEFS_SVH
`define DEMUX16_ROUTER_DEFS_SVH

`define WIDTH_DEFAULT 16
`define CNT_W_DEFAULT 8
`define SEL_A 1'b0
`define SEL_B 1'b1

`endif

// File: rtl/demux16_slot.sv
// Single-entry holding register with load/drain valid flag and accepted-word counter.
module demux16_slot #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             space
);

    // Space is available when empty or when the held word leaves this edge.
    assign space = ~valid | ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            count <= count + 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux16_router.sv
// 1-to-2 router for 16-bit ALU result words into two independently drained holding slots.
module demux16_router
    import demux16_router_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    dest_e dest;
    logic  a_space;
    logic  b_space;
    logic  accept;
    logic  a_load;
    logic  b_load;

    assign dest = dest_e'(in_sel);

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (dest == DEST_B) ? b_space : a_space;
        end
    end

    assign accept = in_valid & in_ready;
    assign a_load = accept & (dest == DEST_A);
    assign b_load = accept & (dest == DEST_B);

    demux16_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .load      (a_load),
        .load_data (in_data),
        .ready     (a_ready),
        .valid     (a_valid),
        .data      (a_data),
        .count     (a_count),
        .space     (a_space)
    );

    demux16_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .load      (b_load),
        .load_data (in_data),
        .ready     (b_ready),
        .valid     (b_valid),
        .data      (b_data),
        .count     (b_count),
        .space     (b_space)
    );

endmodule

// File: tb/tb_demux16_router.sv
// Self-checking bench for demux16_router: directed scenarios plus randomized traffic vs a slot model.
module tb_demux16_router;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: index 0 = destination A, 1 = destination B.
    bit               m_valid [2];
    logic [WIDTH-1:0] m_data  [2];
    logic [CNT_W-1:0] m_count [2];

    always #5 clk = ~clk;

    demux16_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    function automatic bit rdy_of(int s);
        return (s == 1) ? b_ready : a_ready;
    endfunction

    function automatic bit exp_ready();
        int d;
        d = int'(in_sel);
        return !rst && (!m_valid[d] || rdy_of(d));
    endfunction

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        bit   acc;
        int   d;
        bit   rdy [2];
        logic [WIDTH-1:0] word;
        bit   r;
        d      = int'(in_sel);
        acc    = in_valid && exp_ready();
        rdy[0] = a_ready;
        rdy[1] = b_ready;
        word   = in_data;
        r      = rst;
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (r) begin
                m_valid[s] = 1'b0;
                m_data[s]  = '0;
                m_count[s] = '0;
            end else if (acc && d == s) begin
                m_valid[s] = 1'b1;
                m_data[s]  = word;
                m_count[s] = m_count[s] + 1'b1;
            end else if (m_valid[s] && rdy[s]) begin
                m_valid[s] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({a_valid, b_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valids: got %b want 00", {a_valid, b_valid}); end
        n_cmp++;
        if ({a_data, b_data} !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {a_data, b_data}); end
        n_cmp++;
        if ({a_count, b_count} !== 16'h0) begin n_bad++; $display("FAIL reset_counts: got %h want 0", {a_count, b_count}); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_route();
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hA5A5;
        tick();
        in_sel = 1'b1; in_data = 16'h5A5A;
        #1;
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== 16'hA5A5) begin
            n_bad++; $display("FAIL basic_a: got v=%b d=%h want v=1 d=a5a5", a_valid, a_data);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (b_valid !== 1'b1 || b_data !== 16'h5A5A) begin
            n_bad++; $display("FAIL basic_b: got v=%b d=%h want v=1 d=5a5a", b_valid, b_data);
        end
        n_cmp++;
        if (a_valid !== 1'b0) begin n_bad++; $display("FAIL basic_a_drained: got %b want 0", a_valid); end
        n_cmp++;
        if (a_count !== 8'd1 || b_count !== 8'd1) begin
            n_bad++; $display("FAIL basic_counts: got a=%0d b=%0d want 1 1", a_count, b_count);
        end
        tick();
    endtask

    task automatic test_backpressure();
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0001;
        tick();
        in_data = 16'h0002;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got in_ready=%b want 0", in_ready); end
        tick();
        tick();
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== 16'h0001) begin
            n_bad++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=0001", a_valid, a_data);
        end
        in_sel = 1'b1; in_data = 16'h0003;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_isolation: got in_ready=%b want 1", in_ready); end
        tick();
        n_cmp++;
        if (b_valid !== 1'b1 || b_data !== 16'h0003) begin
            n_bad++; $display("FAIL bp_b_load: got v=%b d=%h want v=1 d=0003", b_valid, b_data);
        end
        in_sel = 1'b0; in_data = 16'h0002; a_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got in_ready=%b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== 16'h0002 || a_count !== 8'd3 || b_count !== 8'd2) begin
            n_bad++; $display("FAIL bp_after: got v=%b d=%h ac=%0d bc=%0d want v=1 d=0002 ac=3 bc=2",
                              a_valid, a_data, a_count, b_count);
        end
        b_ready = 1'b1;
        tick();
    endtask

    task automatic test_load_drain();
        logic [CNT_W-1:0] start;
        start = m_count[0];
        a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h1000 + 16'(i);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ld_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            n_cmp++;
            if (a_valid !== 1'b1 || a_data !== 16'h1000 + 16'(i)) begin
                n_bad++; $display("FAIL ld_step[%0d]: got v=%b d=%h want v=1 d=%h", i, a_valid, a_data, 16'h1000 + 16'(i));
            end
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_count !== start + 8'd5) begin n_bad++; $display("FAIL ld_count: got %0d want %0d", a_count, start + 8'd5); end
        tick();
    endtask

    task automatic test_counter_wrap();
        logic [CNT_W-1:0] a0;
        logic [CNT_W-1:0] b0;
        logic [WIDTH-1:0] last;
        int               stalls;
        a0 = m_count[0]; b0 = m_count[1]; stalls = 0; last = '0;
        b_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = WIDTH'($urandom);
            last = in_data;
            #1;
            if (in_ready !== 1'b1) stalls++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (stalls != 0) begin n_bad++; $display("FAIL wrap_stalls: got %0d want 0", stalls); end
        n_cmp++;
        if (b_count !== b0 || a_count !== a0) begin
            n_bad++; $display("FAIL wrap_counts: got a=%0d b=%0d want a=%0d b=%0d", a_count, b_count, a0, b0);
        end
        n_cmp++;
        if (b_data !== last) begin n_bad++; $display("FAIL wrap_last: got %h want %h", b_data, last); end
        tick();
    endtask

    task automatic test_reset_mid();
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1111;
        tick();
        in_sel = 1'b1; in_data = 16'h2222;
        tick();
        n_cmp++;
        if ({a_valid, b_valid} !== 2'b11) begin n_bad++; $display("FAIL mid_full: got %b want 11", {a_valid, b_valid}); end
        a_ready = 1'b1; in_sel = 1'b0; in_data = 16'hBEEF; rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_in_rst: got %b want 0", in_ready); end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({a_valid, b_valid} !== 2'b00 || {a_data, b_data} !== 32'h0 || {a_count, b_count} !== 16'h0) begin
            n_bad++; $display("FAIL mid_cleared: got v=%b%b d=%h/%h c=%0d/%0d want all 0",
                              a_valid, b_valid, a_data, b_data, a_count, b_count);
        end
        tick();
        n_cmp++;
        if (a_valid !== 1'b0 || a_count !== 8'd0) begin
            n_bad++; $display("FAIL mid_not_captured: got v=%b c=%0d want 0 0", a_valid, a_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            in_sel   = 1'($urandom);
            in_data  = WIDTH'($urandom);
            a_ready  = $urandom_range(0, 2) != 0;
            b_ready  = $urandom_range(0, 1) != 0;
            #1;
            n_cmp++;
            if (in_ready !== exp_ready()) begin
                n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_ready());
            end
            n_cmp++;
            if (a_valid !== m_valid[0] || b_valid !== m_valid[1] ||
                a_count !== m_count[0] || b_count !== m_count[1] ||
                (m_valid[0] && a_data !== m_data[0]) || (m_valid[1] && b_data !== m_data[1])) begin
                n_bad++;
                $display("FAIL rnd_state[%0d]: got v=%b%b d=%h/%h c=%0d/%0d want v=%b%b d=%h/%h c=%0d/%0d", i,
                         a_valid, b_valid, a_data, b_data, a_count, b_count,
                         m_valid[0], m_valid[1], m_data[0], m_data[1], m_count[0], m_count[1]);
            end
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_backpressure();
        test_load_drain();
        test_counter_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
